// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and helpers for the round-robin one-hot arbiter.
// Grant is always one-hot or zero, so the index helper can OR indices together.
package rr_arb_pkg;
   localparam int N_REQ            = 8;
   localparam int PTR_W            = 3;
   localparam int DEFAULT_MAX_HOLD = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = idx | PTR_W'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate right by ptr, take the lowest set bit,
// rotate the result back left by ptr.
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] pick_onehot,
   output logic             any_req
);

   logic [N_REQ-1:0] rot;
   logic [N_REQ-1:0] pri;

   // Index arithmetic is kept at PTR_W bits so it wraps mod N_REQ on its own.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PTR_W-1:0] src;
      logic [PTR_W-1:0] dst;
      assign src             = PTR_W'(gi) + ptr;
      assign dst             = PTR_W'(gi) - ptr;
      assign rot[gi]         = req[src];
      assign pick_onehot[gi] = pri[dst];
   end

   assign pri     = rot & (~rot + 1'b1);
   assign any_req = |req;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// 8-way round-robin arbiter with a registered one-hot grant, released on done,
// requester withdrawal, or a MAX_HOLD-cycle limit (which pulses timeout).
module rr_onehot_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_reg, state_next;
   logic [PTR_W-1:0] ptr_reg, ptr_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [N_REQ-1:0] grant_reg, grant_next;
   logic             timeout_reg, timeout_next;
   logic             release_grant;

   logic [N_REQ-1:0] pick_onehot;
   logic             any_req;

   rr_pick u_pick (
      .req         (req),
      .ptr         (ptr_reg),
      .pick_onehot (pick_onehot),
      .any_req     (any_req)
   );

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      cnt_next      = cnt_reg;
      grant_next    = grant_reg;
      timeout_next  = 1'b0;
      release_grant = 1'b0;

      case (state_reg)
         IDLE: begin
            if (any_req) begin
               grant_next = pick_onehot;
               cnt_next   = '0;
               state_next = GRANT;
            end
         end
         GRANT: begin
            // done wins over the hold limit, so a collision gives no timeout pulse
            if (done || ((req & grant_reg) == '0)) begin
               release_grant = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               release_grant = 1'b1;
               timeout_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end

            if (release_grant) begin
               grant_next = '0;
               ptr_next   = onehot_idx(grant_reg) + 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         cnt_reg     <= '0;
         grant_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         cnt_reg     <= cnt_next;
         grant_reg   <= grant_next;
         timeout_reg <= timeout_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = |grant_reg;
   assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench: a behavioural model pushes the expected outputs for every
// clock edge, and an independent monitor pops and compares them.
module tb_rr_onehot_arbiter;

   localparam int MH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   typedef struct {
      logic [7:0] g;
      logic       v;
      logic       t;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cycle = 0;

   rr_onehot_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the grant, how long it has been visible,
   // and which requester is searched first next time.
   initial begin : model
      int   owner;
      int   held;
      int   mptr;
      int   idx;
      bit   found;
      logic e_to;
      exp_t e;
      owner = -1;
      held  = 0;
      mptr  = 0;
      forever begin
         @(posedge clk);
         e_to = 1'b0;
         if (!rst_n) begin
            owner = -1;
            held  = 0;
            mptr  = 0;
         end else if (owner < 0) begin
            if (req != 8'h00) begin
               found = 1'b0;
               for (int k = 0; k < 8; k++) begin
                  idx = (mptr + k) % 8;
                  if (!found && req[idx]) begin
                     owner = idx;
                     found = 1'b1;
                  end
               end
               held = 1;
            end
         end else begin
            if (done || !req[owner]) begin
               mptr  = (owner + 1) % 8;
               owner = -1;
            end else if (held == MH) begin
               e_to  = 1'b1;
               mptr  = (owner + 1) % 8;
               owner = -1;
            end else begin
               held++;
            end
         end
         e.g = (owner < 0) ? 8'h00 : 8'(1 << owner);
         e.v = (owner >= 0);
         e.t = e_to;
         sb.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      logic prev_v;
      prev_v = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty cycle=%0d: no expected entry available", cycle);
         end else begin
            e = sb.pop_front();
            if (grant !== e.g || grant_valid !== e.v || timeout !== e.t) begin
               bad++;
               $display("FAIL outputs cycle=%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                        cycle, grant, grant_valid, timeout, e.g, e.v, e.t);
            end
            if (e.v && !prev_v) $display("cycle %0d: grant %h", cycle, e.g);
            if (e.t) $display("cycle %0d: timeout release", cycle);
            prev_v = e.v;
         end
         total++;
         if (!$onehot0(grant) || (grant_valid !== (|grant))) begin
            bad++;
            $display("FAIL onehot cycle=%0d: got grant=%h valid=%b, want at most one bit and valid=|grant",
                     cycle, grant, grant_valid);
         end
      end
   end

   task automatic cyc(input logic r, input logic [7:0] q, input logic d, input int n);
      rst_n = r;
      req   = q;
      done  = d;
      repeat (n) @(negedge clk);
   endtask

   initial begin : driver
      logic [7:0] rq;
      // reset with all requests up, then idle
      cyc(1'b0, 8'hFF, 1'b0, 2);
      cyc(1'b1, 8'h00, 1'b0, 3);
      // single request released by done
      cyc(1'b1, 8'h08, 1'b0, 3);
      cyc(1'b1, 8'h08, 1'b1, 1);
      cyc(1'b1, 8'h00, 1'b0, 3);
      // round-robin sweep from ptr=0 with done held high
      cyc(1'b0, 8'h00, 1'b0, 1);
      cyc(1'b1, 8'hFF, 1'b1, 20);
      cyc(1'b1, 8'h00, 1'b0, 2);
      // hold-limit timeout, then re-grant after the idle cycle
      cyc(1'b1, 8'h20, 1'b0, 40);
      cyc(1'b1, 8'h00, 1'b0, 2);
      // bring ptr to 5, then withdraw and wrap
      cyc(1'b0, 8'h00, 1'b0, 1);
      cyc(1'b1, 8'h10, 1'b0, 2);
      cyc(1'b1, 8'h10, 1'b1, 1);
      cyc(1'b1, 8'h00, 1'b0, 1);
      cyc(1'b1, 8'h21, 1'b0, 3);
      cyc(1'b1, 8'h01, 1'b0, 4);
      cyc(1'b1, 8'h00, 1'b0, 2);
      // reset in the middle of a grant
      cyc(1'b1, 8'h02, 1'b0, 3);
      cyc(1'b0, 8'h02, 1'b0, 1);
      cyc(1'b1, 8'h00, 1'b0, 2);
      // done in the last allowed hold cycle
      cyc(1'b1, 8'h40, 1'b0, 16);
      cyc(1'b1, 8'h40, 1'b1, 1);
      cyc(1'b1, 8'h00, 1'b0, 2);
      // randomized traffic; requests change rarely so timeouts still occur
      rq = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            rq = 8'($urandom);
            if ($urandom_range(0, 1) == 0) rq = rq & 8'($urandom);
         end
         cyc(($urandom_range(0, 199) != 0), rq, ($urandom_range(0, 7) == 0), 1);
      end
      cyc(1'b1, 8'h00, 1'b0, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
